// File: rtl/bw_clk_cl_hdr_mc_if.sv
// bw_clk_cl_hdr_mc_if
// Groups the request, scan and per-cluster output signals of the multi-cluster
// clock-cluster header so they travel as one bundle. gclk and grst are kept as
// plain ports on the header itself.
//
// Signals
//   grst_l          global reset request, active-low, unsynchronised
//   gdbginit_l      global debug-init request, active-low, unsynchronised
//   cluster_cken    per-cluster clock-enable request
//   se, si          scan enable, scan in
//   rclk_en         registered per-cluster clock enable
//   cluster_grst_l  per-cluster reset, active-low
//   dbginit_l       per-cluster debug init, active-low
//   so              scan out
//   rst_done        high once every cluster is out of reset
//
// Modports
//   master  the side that drives the requests (system / testbench)
//   slave   the header
interface bw_clk_cl_hdr_mc_if #(
    parameter int NUM_CL = 4
);
    logic              grst_l;
    logic              gdbginit_l;
    logic [NUM_CL-1:0] cluster_cken;
    logic              se;
    logic              si;
    logic [NUM_CL-1:0] rclk_en;
    logic [NUM_CL-1:0] cluster_grst_l;
    logic [NUM_CL-1:0] dbginit_l;
    logic              so;
    logic              rst_done;

    modport master (
        output grst_l, gdbginit_l, cluster_cken, se, si,
        input  rclk_en, cluster_grst_l, dbginit_l, so, rst_done
    );

    modport slave (
        input  grst_l, gdbginit_l, cluster_cken, se, si,
        output rclk_en, cluster_grst_l, dbginit_l, so, rst_done
    );
endinterface

// File: rtl/bw_clk_cl_hdr_mc.sv
// bw_clk_cl_hdr_mc
// Clock-cluster header serving NUM_CL clusters from the single clock gclk.
// The global reset and debug-init requests are synchronised, then cluster
// resets are released one cluster at a time, STAGGER_CYC cycles apart, so the
// clusters do not all start switching on the same edge. Per-cluster clock
// enables are registered, and the synchroniser flops double as a scan chain
// (si -> reset sync -> debug sync -> so).
//
// Ports
//   gclk   global clock, the only clock
//   grst   synchronous active-high reset of this header
//   bus    bw_clk_cl_hdr_mc_if.slave carrying requests, scan and outputs
//
// Parameters
//   NUM_CL       number of clusters (>=1)
//   SYNC_STAGES  synchroniser depth (>=2)
//   STAGGER_CYC  cycles between successive cluster releases (>=1)
module bw_clk_cl_hdr_mc #(
    parameter int NUM_CL      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER_CYC = 4
) (
    input  logic                gclk,
    input  logic                grst,
    bw_clk_cl_hdr_mc_if.slave   bus
);

    // Largest counter value ever needed: the last release point plus the one
    // extra STAGGER cycle before RUN. The counter saturates there.
    localparam int CNT_MAX = (NUM_CL - 1) * STAGGER_CYC + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
    logic [NUM_CL-1:0]   cl_rst_l, cl_rst_l_next, stag_mask;
    logic [NUM_CL-1:0]   dbg_l;
    logic [NUM_CL-1:0]   rclk_en_q;
    logic [SYNC_STAGES-1:0] grst_sync, dbg_sync;
    logic                grst_s, dbg_s;

    assign grst_s = grst_sync[SYNC_STAGES-1];
    assign dbg_s  = dbg_sync[SYNC_STAGES-1];

    // Synchroniser chains for the two asynchronous requests. In scan mode the
    // same flops form one shift register: si feeds the reset chain, the reset
    // chain feeds the debug chain, and the end of the debug chain is so.
    always_ff @(posedge gclk) begin
        if (grst) begin
            grst_sync <= '0;
            dbg_sync  <= '0;
        end else if (bus.se) begin
            grst_sync <= {grst_sync[SYNC_STAGES-2:0], bus.si};
            dbg_sync  <= {dbg_sync[SYNC_STAGES-2:0], grst_sync[SYNC_STAGES-1]};
        end else begin
            grst_sync <= {grst_sync[SYNC_STAGES-2:0], bus.grst_l};
            dbg_sync  <= {dbg_sync[SYNC_STAGES-2:0], bus.gdbginit_l};
        end
    end

    // Saturating increment and the set of clusters whose release point has
    // been reached at that incremented count. Cluster i is due once the
    // count reaches i*STAGGER_CYC; OR-ing with the current value keeps
    // released clusters released.
    always_comb begin
        cnt_inc   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
        stag_mask = '0;
        for (int i = 0; i < NUM_CL; i++) begin
            stag_mask[i] = (32'(cnt_inc) >= 32'(i * STAGGER_CYC));
        end
    end

    // Next-state logic of the release sequencer. Scan mode freezes
    // everything. Loss of the synchronised reset request wins over every
    // other transition and drops all clusters back into reset. Leaving HOLD
    // releases cluster 0 immediately because the counter restarts at zero.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cl_rst_l_next = cl_rst_l;
        if (!bus.se) begin
            if (!grst_s) begin
                state_next    = HOLD;
                cnt_next      = '0;
                cl_rst_l_next = '0;
            end else begin
                case (state)
                    HOLD: begin
                        state_next    = STAGGER;
                        cnt_next      = '0;
                        cl_rst_l_next = NUM_CL'(1);
                    end
                    STAGGER: begin
                        cnt_next      = cnt_inc;
                        cl_rst_l_next = cl_rst_l | stag_mask;
                        if (cl_rst_l[NUM_CL-1]) begin
                            state_next = RUN;
                        end
                    end
                    RUN: begin
                        cl_rst_l_next = '1;
                    end
                    default: begin
                        state_next    = HOLD;
                        cnt_next      = '0;
                        cl_rst_l_next = '0;
                    end
                endcase
            end
        end
    end

    // State, counter and output registers. Debug init follows the next
    // cluster reset value gated by the synchronised debug request, so a
    // cluster held in reset always sees debug init asserted. Clock enables
    // are forced on while scanning so the shift is always clocked.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state     <= HOLD;
            cnt       <= '0;
            cl_rst_l  <= '0;
            dbg_l     <= '0;
            rclk_en_q <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cl_rst_l  <= cl_rst_l_next;
            rclk_en_q <= bus.se ? '1 : bus.cluster_cken;
            if (!bus.se) begin
                dbg_l <= {NUM_CL{dbg_s}} & cl_rst_l_next;
            end
        end
    end

    assign bus.rclk_en        = rclk_en_q;
    assign bus.cluster_grst_l = cl_rst_l;
    assign bus.dbginit_l      = dbg_l;
    assign bus.so             = dbg_sync[SYNC_STAGES-1];
    assign bus.rst_done       = (state == RUN);

endmodule

// File: tb/tb_bw_clk_cl_hdr_mc.sv
// tb_bw_clk_cl_hdr_mc
// Directed bench for bw_clk_cl_hdr_mc with NUM_CL=4, SYNC_STAGES=2,
// STAGGER_CYC=4. A vector table covers the reset-release sequence and the
// clock-enable pipeline; hand-written sequences cover abort, debug init,
// scan and reset priority.
module tb_bw_clk_cl_hdr_mc;

    logic gclk;
    logic grst;

    bw_clk_cl_hdr_mc_if #(.NUM_CL(4)) bus ();

    bw_clk_cl_hdr_mc #(
        .NUM_CL(4),
        .SYNC_STAGES(2),
        .STAGGER_CYC(4)
    ) dut (
        .gclk(gclk),
        .grst(grst),
        .bus(bus)
    );

    typedef struct {
        logic       grst_l;
        logic       gdbginit_l;
        logic       se;
        logic       si;
        logic [3:0] cken;
        logic [3:0] exp_cl;
        logic [3:0] exp_rclk;
        logic [3:0] exp_dbg;
        logic       exp_done;
    } vec_t;

    vec_t vecs[16];
    int   checks;
    int   passed;
    logic [3:0] pat;

    // Free-running 10-unit clock.
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Advance one clock and step 1 unit past the edge before sampling.
    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // One named comparison; all values are carried as 4 bits.
    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector's inputs and clock it.
    task automatic applyStimulus(input vec_t v);
        bus.grst_l       = v.grst_l;
        bus.gdbginit_l   = v.gdbginit_l;
        bus.se           = v.se;
        bus.si           = v.si;
        bus.cluster_cken = v.cken;
        tick();
    endtask

    // Pulse the header reset for one edge with the requests idle.
    task automatic doReset();
        grst             = 1'b1;
        bus.grst_l       = 1'b1;
        bus.gdbginit_l   = 1'b1;
        bus.se           = 1'b0;
        bus.si           = 1'b0;
        tick();
        grst = 1'b0;
    endtask

    task automatic waitRun();
        int n;
        n = 0;
        while (!bus.rst_done && n < 40) begin
            tick();
            n++;
        end
        checkOutput("run_reached", {3'b0, bus.rst_done}, 4'b0001);
    endtask

    initial begin
        checks = 0;
        passed = 0;

        // Vector k is clocked by edge k+1 after grst falls.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'b0000, 4'h1, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'b0000, 4'h2, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'b0001, 4'h3, 4'b0001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 4'b0001, 4'h4, 4'b0001, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'b0001, 4'h5, 4'b0001, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'b0001, 4'h6, 4'b0001, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'b0011, 4'h7, 4'b0011, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 4'b0011, 4'h8, 4'b0011, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'b0011, 4'h9, 4'b0011, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'b0011, 4'hA, 4'b0011, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hB, 4'b0111, 4'hB, 4'b0111, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 4'b0111, 4'hC, 4'b0111, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hD, 4'b0111, 4'hD, 4'b0111, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'b0111, 4'hE, 4'b0111, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'b1111, 4'hF, 4'b1111, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'b1111, 4'hA, 4'b1111, 1'b1};

        // Reset state.
        grst             = 1'b1;
        bus.grst_l       = 1'b1;
        bus.gdbginit_l   = 1'b1;
        bus.se           = 1'b0;
        bus.si           = 1'b1;
        bus.cluster_cken = 4'hF;
        tick();
        tick();
        checkOutput("rst_cl",   bus.cluster_grst_l, 4'b0000);
        checkOutput("rst_rclk", bus.rclk_en,        4'b0000);
        checkOutput("rst_dbg",  bus.dbginit_l,      4'b0000);
        checkOutput("rst_done", {3'b0, bus.rst_done}, 4'b0000);
        checkOutput("rst_so",   {3'b0, bus.so},       4'b0000);

        // Staggered release plus clock-enable pipeline, table driven.
        grst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("v%0d_cl", k),   bus.cluster_grst_l, vecs[k].exp_cl);
            checkOutput($sformatf("v%0d_rclk", k), bus.rclk_en,        vecs[k].exp_rclk);
            checkOutput($sformatf("v%0d_dbg", k),  bus.dbginit_l,      vecs[k].exp_dbg);
            checkOutput($sformatf("v%0d_done", k), {3'b0, bus.rst_done}, {3'b0, vecs[k].exp_done});
        end

        // Debug init pulse in RUN: low on three edges, visible from the third.
        bus.gdbginit_l = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 3) bus.gdbginit_l = 1'b1;
            checkOutput($sformatf("dbg_t%0d", t), bus.dbginit_l,
                        (t >= 3 && t <= 5) ? 4'b0000 : 4'b1111);
            checkOutput($sformatf("dbg_cl_t%0d", t), bus.cluster_grst_l, 4'b1111);
        end

        // Mid-stagger abort one cycle after cluster 1 releases, then restart.
        doReset();
        for (int t = 1; t <= 7; t++) tick();
        checkOutput("abort_e7", bus.cluster_grst_l, 4'b0011);
        bus.grst_l = 1'b0;
        tick();
        checkOutput("abort_e8", bus.cluster_grst_l, 4'b0011);
        tick();
        checkOutput("abort_e9", bus.cluster_grst_l, 4'b0011);
        tick();
        checkOutput("abort_e10", bus.cluster_grst_l, 4'b0000);
        checkOutput("abort_dbg", bus.dbginit_l,      4'b0000);
        checkOutput("abort_done", {3'b0, bus.rst_done}, 4'b0000);
        bus.grst_l = 1'b1;
        tick();
        checkOutput("restart_e11", bus.cluster_grst_l, 4'b0000);
        tick();
        checkOutput("restart_e12", bus.cluster_grst_l, 4'b0000);
        tick();
        checkOutput("restart_e13", bus.cluster_grst_l, 4'b0001);
        tick();
        tick();
        tick();
        checkOutput("restart_e16", bus.cluster_grst_l, 4'b0001);
        tick();
        checkOutput("restart_e17", bus.cluster_grst_l, 4'b0011);
        waitRun();

        // Clock-enable pipeline then scan shift in RUN.
        bus.cluster_cken = 4'b1010;
        tick();
        checkOutput("cken_1010", bus.rclk_en, 4'b1010);
        pat = 4'b1101;
        bus.se = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.si = (k < 4) ? pat[k] : 1'b1;
            tick();
            checkOutput($sformatf("scan_rclk_%0d", k), bus.rclk_en, 4'b1111);
            checkOutput($sformatf("scan_cl_%0d", k), bus.cluster_grst_l, 4'b1111);
            checkOutput($sformatf("scan_done_%0d", k), {3'b0, bus.rst_done}, 4'b0001);
            if (k >= 3) begin
                checkOutput($sformatf("scan_so_%0d", k), {3'b0, bus.so},
                            {3'b0, (k < 7) ? pat[k-3] : 1'b1});
            end
        end
        bus.se = 1'b0;
        tick();
        checkOutput("post_scan_done", {3'b0, bus.rst_done}, 4'b0001);
        checkOutput("post_scan_rclk", bus.rclk_en, 4'b1010);

        // Reset priority over scan during STAGGER.
        doReset();
        bus.cluster_cken = 4'hF;
        for (int t = 1; t <= 5; t++) tick();
        checkOutput("prio_pre_cl", bus.cluster_grst_l, 4'b0001);
        grst   = 1'b1;
        bus.se = 1'b1;
        bus.si = 1'b1;
        tick();
        checkOutput("prio_cl",   bus.cluster_grst_l, 4'b0000);
        checkOutput("prio_rclk", bus.rclk_en,        4'b0000);
        checkOutput("prio_dbg",  bus.dbginit_l,      4'b0000);
        checkOutput("prio_done", {3'b0, bus.rst_done}, 4'b0000);
        checkOutput("prio_so",   {3'b0, bus.so},       4'b0000);
        grst   = 1'b0;
        bus.se = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
